// File: rtl/alarm_bank.sv
// Multi-channel alarm controller: compares the master time against N programmable alarms,
// rings the lowest-index fired alarm, and queues the others. Supports snooze and dismiss.
module alarm_bank #(
  parameter  int unsigned N_ALARMS    = 4,
  parameter  int unsigned RING_SECS   = 60,
  parameter  int unsigned SNOOZE_SECS = 300,
  parameter  int unsigned MAX_SNOOZE  = 3,
  localparam int unsigned AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
  localparam int unsigned SW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    sec_tick,
  input  logic [6:0]              tmin,
  input  logic [6:0]              thrs,
  input  logic [2:0]              tday,
  input  logic [7*N_ALARMS-1:0]   amin,
  input  logic [7*N_ALARMS-1:0]   ahrs,
  input  logic [7*N_ALARMS-1:0]   aday,
  input  logic [N_ALARMS-1:0]     aen,
  input  logic                    snooze,
  input  logic                    dismiss,
  output logic                    buzz,
  output logic                    snoozing,
  output logic [AW-1:0]           active_id,
  output logic [N_ALARMS-1:0]     pending,
  output logic [SW-1:0]           snooze_cnt
);

  localparam int unsigned MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int unsigned CW       = (MAX_SECS > 1) ? $clog2(MAX_SECS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RING,
    SNOOZE
  } state_t;

  state_t              state;
  logic [N_ALARMS-1:0] match;
  logic [N_ALARMS-1:0] prev_match;
  logic [N_ALARMS-1:0] trigger;
  logic [N_ALARMS-1:0] pend_all;
  logic [N_ALARMS-1:0] sel_oh;
  logic [AW-1:0]       sel_id;
  logic [CW-1:0]       ring_ctr;
  logic [CW-1:0]       snz_ctr;

  // Per-channel time match; the padded mask bit makes tday==7 never match.
  always_comb begin
    logic [7:0] dm;
    match = '0;
    dm    = '0;
    for (int i = 0; i < int'(N_ALARMS); i++) begin
      dm       = {1'b0, aday[7*i +: 7]};
      match[i] = aen[i] && (tmin == amin[7*i +: 7]) && (thrs == ahrs[7*i +: 7]) && dm[tday];
    end
  end

  assign trigger  = match & ~prev_match;
  assign pend_all = pending | trigger;

  // Lowest-index pick among pending and fresh triggers.
  always_comb begin
    sel_id = '0;
    sel_oh = '0;
    for (int i = int'(N_ALARMS) - 1; i >= 0; i--) begin
      if (pend_all[i]) begin
        sel_id = AW'(i);
        sel_oh = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= IDLE;
      prev_match <= '1;
      pending    <= '0;
      buzz       <= 1'b0;
      snoozing   <= 1'b0;
      active_id  <= '0;
      snooze_cnt <= '0;
      ring_ctr   <= '0;
      snz_ctr    <= '0;
    end else begin
      prev_match <= match;
      pending    <= pend_all;
      case (state)
        IDLE: begin
          if (|pend_all) begin
            state      <= RING;
            buzz       <= 1'b1;
            active_id  <= sel_id;
            pending    <= pend_all & ~sel_oh;
            ring_ctr   <= '0;
            snooze_cnt <= '0;
          end
        end
        RING: begin
          if (dismiss) begin
            state <= IDLE;
            buzz  <= 1'b0;
          end else if (snooze && (snooze_cnt < SW'(MAX_SNOOZE))) begin
            state      <= SNOOZE;
            buzz       <= 1'b0;
            snoozing   <= 1'b1;
            snooze_cnt <= snooze_cnt + SW'(1);
            snz_ctr    <= '0;
          end else if (sec_tick) begin
            if (ring_ctr == CW'(RING_SECS - 1)) begin
              state <= IDLE;
              buzz  <= 1'b0;
            end else begin
              ring_ctr <= ring_ctr + CW'(1);
            end
          end
        end
        SNOOZE: begin
          if (dismiss) begin
            state    <= IDLE;
            snoozing <= 1'b0;
          end else if (sec_tick) begin
            if (snz_ctr == CW'(SNOOZE_SECS - 1)) begin
              state    <= RING;
              buzz     <= 1'b1;
              snoozing <= 1'b0;
              ring_ctr <= '0;
            end else begin
              snz_ctr <= snz_ctr + CW'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          buzz     <= 1'b0;
          snoozing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: ring, timeout, snooze limits, queuing, masks and reset.
module tb_alarm_bank;

  localparam int unsigned N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          sec_tick;
  logic [6:0]    tmin, thrs;
  logic [2:0]    tday;
  logic [7*N-1:0] amin, ahrs, aday;
  logic [N-1:0]  aen;
  logic          snooze, dismiss;
  logic          buzz, snoozing;
  logic [1:0]    active_id;
  logic [N-1:0]  pending;
  logic [1:0]    snooze_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  alarm_bank #(.N_ALARMS(4), .RING_SECS(60), .SNOOZE_SECS(300), .MAX_SNOOZE(3)) dut (
    .clk(clk), .Reset(reset), .sec_tick(sec_tick), .tmin(tmin), .thrs(thrs), .tday(tday),
    .amin(amin), .ahrs(ahrs), .aday(aday), .aen(aen), .snooze(snooze), .dismiss(dismiss),
    .buzz(buzz), .snoozing(snoozing), .active_id(active_id), .pending(pending),
    .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      sec_tick = 1'b1;
      clk1();
      sec_tick = 1'b0;
    end
  endtask

  task automatic set_time(input int h, input int m, input int d);
    thrs = 7'(h);
    tmin = 7'(m);
    tday = 3'(d);
  endtask

  task automatic set_ch(input int i, input int h, input int m, input logic [6:0] mask);
    ahrs[7*i +: 7] = 7'(h);
    amin[7*i +: 7] = 7'(m);
    aday[7*i +: 7] = mask;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    clk1();
    snooze = 1'b0;
  endtask

  task automatic pulse_dismiss();
    dismiss = 1'b1;
    clk1();
    dismiss = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sec_tick = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    amin = '0; ahrs = '0; aday = '0; aen = '0;
    set_time(0, 0, 0);
    clk1(); clk1();
    chk("rst_buzz", 32'(buzz), 0);
    chk("rst_snoozing", 32'(snoozing), 0);
    chk("rst_active_id", 32'(active_id), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_snooze_cnt", 32'(snooze_cnt), 0);

    set_ch(0, 6, 0, 7'h7F);
    set_ch(1, 7, 30, 7'h7F);
    set_ch(2, 6, 0, 7'h7F);
    set_ch(3, 8, 0, 7'b0000010);
    aen = 4'b1111;
    set_time(7, 29, 3);
    reset = 1'b0;
    clk1();
    chk("pre_match_buzz", 32'(buzz), 0);

    // Single ring with auto-timeout after 60 ticks.
    set_time(7, 30, 3);
    clk1();
    chk("ring_buzz", 32'(buzz), 1);
    chk("ring_id", 32'(active_id), 1);
    ticks(59);
    chk("tick59_buzz", 32'(buzz), 1);
    ticks(1);
    chk("timeout_buzz", 32'(buzz), 0);
    chk("timeout_pending", 32'(pending), 0);

    // Snooze three times, fourth ignored, then dismiss.
    set_time(7, 31, 3); clk1();
    set_time(7, 30, 3); clk1();
    chk("ring2_buzz", 32'(buzz), 1);
    pulse_snooze();
    chk("snz1_snoozing", 32'(snoozing), 1);
    chk("snz1_buzz", 32'(buzz), 0);
    chk("snz1_cnt", 32'(snooze_cnt), 1);
    ticks(299);
    chk("snz1_299_snoozing", 32'(snoozing), 1);
    ticks(1);
    chk("rering1_buzz", 32'(buzz), 1);
    chk("rering1_snoozing", 32'(snoozing), 0);
    pulse_snooze();
    chk("snz2_cnt", 32'(snooze_cnt), 2);
    ticks(300);
    pulse_snooze();
    chk("snz3_cnt", 32'(snooze_cnt), 3);
    ticks(300);
    chk("rering3_buzz", 32'(buzz), 1);
    pulse_snooze();
    chk("snz4_buzz", 32'(buzz), 1);
    chk("snz4_snoozing", 32'(snoozing), 0);
    chk("snz4_cnt", 32'(snooze_cnt), 3);
    pulse_dismiss();
    chk("dismiss_buzz", 32'(buzz), 0);

    // Two channels in the same minute: lowest first, other queued.
    set_time(5, 59, 3); clk1();
    set_time(6, 0, 3); clk1();
    chk("dual_buzz", 32'(buzz), 1);
    chk("dual_id", 32'(active_id), 0);
    chk("dual_pending", 32'(pending), 32'h4);
    pulse_dismiss();
    chk("dual_gap_buzz", 32'(buzz), 0);
    chk("dual_gap_pending", 32'(pending), 32'h4);
    clk1();
    chk("dual_next_buzz", 32'(buzz), 1);
    chk("dual_next_id", 32'(active_id), 2);
    chk("dual_next_pending", 32'(pending), 0);
    pulse_dismiss();

    // Day mask excludes tday=3; disabled channels; tday=7 never matches.
    set_time(7, 59, 3); clk1();
    set_time(8, 0, 3); clk1(); clk1();
    chk("mask_buzz", 32'(buzz), 0);
    chk("mask_pending", 32'(pending), 0);
    aen = 4'b1010;
    set_time(5, 59, 3); clk1();
    set_time(6, 0, 3); clk1(); clk1();
    chk("aen_buzz", 32'(buzz), 0);
    chk("aen_pending", 32'(pending), 0);
    aen = 4'b1111;
    set_time(7, 29, 7); clk1();
    set_time(7, 30, 7); clk1(); clk1();
    chk("day7_buzz", 32'(buzz), 0);
    chk("day7_pending", 32'(pending), 0);

    // Snooze and dismiss together in RING: dismiss wins, count kept.
    set_time(7, 29, 3); clk1();
    set_time(7, 30, 3); clk1();
    pulse_snooze();
    ticks(300);
    chk("sd_ring_buzz", 32'(buzz), 1);
    snooze = 1'b1; dismiss = 1'b1;
    clk1();
    snooze = 1'b0; dismiss = 1'b0;
    chk("sd_buzz", 32'(buzz), 0);
    chk("sd_snoozing", 32'(snoozing), 0);
    chk("sd_cnt", 32'(snooze_cnt), 1);

    // Reset within the matching minute suppresses that minute's fire.
    set_time(7, 29, 0); clk1();
    set_time(7, 30, 0); reset = 1'b1; clk1();
    reset = 1'b0;
    clk1(); clk1(); clk1();
    chk("rst_minute_buzz", 32'(buzz), 0);
    chk("rst_minute_pending", 32'(pending), 0);
    set_time(7, 31, 0); clk1();
    set_time(7, 30, 1); clk1();
    chk("next_day_buzz", 32'(buzz), 1);
    chk("next_day_id", 32'(active_id), 1);
    pulse_dismiss();

    // Reset during SNOOZE with ch3 pending.
    set_time(7, 29, 1); clk1();
    set_ch(3, 7, 30, 7'h7F);
    set_time(7, 30, 1); clk1();
    chk("q_id", 32'(active_id), 1);
    chk("q_pending", 32'(pending), 32'h8);
    pulse_snooze();
    chk("q_snoozing", 32'(snoozing), 1);
    chk("q_pending2", 32'(pending), 32'h8);
    reset = 1'b1; clk1();
    reset = 1'b0;
    chk("srst_buzz", 32'(buzz), 0);
    chk("srst_snoozing", 32'(snoozing), 0);
    chk("srst_id", 32'(active_id), 0);
    chk("srst_pending", 32'(pending), 0);
    chk("srst_cnt", 32'(snooze_cnt), 0);
    clk1(); clk1();
    chk("srst_after_buzz", 32'(buzz), 0);
    chk("srst_after_pending", 32'(pending), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
